// File: rtl/uart_fifo_drain.sv
// uart_fifo_drain
//   Pops bytes from the 16-entry sample FIFO and sends each one as a UART frame.
//   The frame is 8 data bits sent LSB first, an optional parity bit, and 1 or 2
//   stop bits. A 16-bit counter records how many frames have been completed.
//
// Parameters
//   CLKS_PER_BIT : sys_clock cycles per UART bit (must be 2 or more)
//   PARITY       : 0 = none, 1 = even, 2 = odd
//   STOP_BITS    : 1 or 2
//
// Ports
//   sys_clock   in   system clock; all state changes on its rising edge
//   reset       in   asynchronous reset, active high
//   enable      in   allows a new frame to start; sampled only while idle
//   fifo_empty  in   FIFO isEmpty flag
//   fifo_data   in   FIFO registered read data
//   fifo_rd_en  out  one-cycle read pulse to the FIFO
//   tx          out  UART serial line; idles high
//   busy        out  high from FETCH through the end of the last stop bit
//   frame_done  out  one-cycle pulse after the last stop bit
//   bytes_sent  out  completed-frame count; wraps at 16 bits
module uart_fifo_drain #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic        sys_clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_rd_en,
    output logic        tx,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] bytes_sent
);

    localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          parity_bit, parity_bit_n;
    logic          tx_n, rd_en_n, busy_n, done_n;
    logic [15:0]   bytes_n;

    logic          bit_end;
    logic [CW-1:0] baud_step;

    assign bit_end   = (baud_cnt == CNT_LAST);
    assign baud_step = bit_end ? '0 : baud_cnt + 1'b1;

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            bytes_sent <= '0;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_cnt_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            parity_bit <= parity_bit_n;
            tx         <= tx_n;
            fifo_rd_en <= rd_en_n;
            busy       <= busy_n;
            frame_done <= done_n;
            bytes_sent <= bytes_n;
        end
    end

    // Every output is registered: this block computes the value each register
    // takes at the next edge, so tx changes on the edge that ends a bit time.
    always_comb begin
        state_n      = state;
        baud_cnt_n   = baud_cnt;
        bit_idx_n    = bit_idx;
        shreg_n      = shreg;
        parity_bit_n = parity_bit;
        tx_n         = tx;
        rd_en_n      = 1'b0;
        busy_n       = busy;
        done_n       = 1'b0;
        bytes_n      = bytes_sent;

        case (state)
            S_IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (enable && !fifo_empty) begin
                    state_n = S_FETCH;
                    rd_en_n = 1'b1;
                    busy_n  = 1'b1;
                end
            end

            // The FIFO registers d_out at the end of this cycle.
            S_FETCH: state_n = S_LATCH;

            // d_out is valid now; the FIFO advances its read address on the
            // falling edge of read_en, so fifo_empty is settled again long
            // before IDLE is re-entered.
            S_LATCH: begin
                shreg_n      = fifo_data;
                parity_bit_n = (PARITY == 2) ? ~^fifo_data : ^fifo_data;
                tx_n         = 1'b0;
                baud_cnt_n   = '0;
                bit_idx_n    = '0;
                state_n      = S_START;
            end

            S_START: begin
                baud_cnt_n = baud_step;
                if (bit_end) begin
                    tx_n      = shreg[0];
                    shreg_n   = {1'b0, shreg[7:1]};
                    bit_idx_n = '0;
                    state_n   = S_DATA;
                end
            end

            // shreg[0] always holds the next data bit to drive.
            S_DATA: begin
                baud_cnt_n = baud_step;
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        bit_idx_n = '0;
                        if (PARITY != 0) begin
                            tx_n    = parity_bit;
                            state_n = S_PARITY;
                        end else begin
                            tx_n    = 1'b1;
                            state_n = S_STOP;
                        end
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = shreg[0];
                        shreg_n   = {1'b0, shreg[7:1]};
                    end
                end
            end

            S_PARITY: begin
                baud_cnt_n = baud_step;
                if (bit_end) begin
                    tx_n      = 1'b1;
                    bit_idx_n = '0;
                    state_n   = S_STOP;
                end
            end

            // bit_idx is reused to count stop bits.
            S_STOP: begin
                baud_cnt_n = baud_step;
                tx_n       = 1'b1;
                if (bit_end) begin
                    if (bit_idx == STOP_LAST) begin
                        bit_idx_n = '0;
                        state_n   = S_IDLE;
                        done_n    = 1'b1;
                        busy_n    = 1'b0;
                        bytes_n   = bytes_sent + 16'd1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end

            default: begin
                state_n = S_IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/uart_fifo_drain.md
# uart_fifo_drain

Downstream consumer of the 16-entry sample FIFO: whenever the FIFO is non-empty and the block is enabled, it pops one byte using the FIFO's single-cycle read pulse protocol and serializes it onto a UART TX line. Supported framing is 8 data bits, optional parity, and 1 or 2 stop bits. It sits between the FIFO and the board UART pin and carries buffered vibration samples to the host. It keeps a running count of bytes sent for status and debug.

## Interface
- CLKS_PER_BIT, default 434: `sys_clock` cycles per UART bit (50 MHz / 115200). Legal range is 2 or more.
- PARITY, default 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, default 1: legal values are 1 or 2.
- sys_clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  when high, the block may start a new frame. It is sampled only in IDLE.
- fifo_empty  input  1  the FIFO's isEmpty flag.
- fifo_data  input  8  the FIFO's registered read data (d_out).
- fifo_rd_en  output  1  one-cycle read pulse to the FIFO's read_en.
- tx  output  1  UART serial output; idles high.
- busy  output  1  high from FETCH through the end of the last stop bit.
- frame_done  output  1  one-cycle pulse in the cycle after the last stop bit completes.
- bytes_sent  output  16  count of completed frames; wraps from 0xFFFF to 0x0000.

## Operation
- Reset values (asynchronous, all outputs registered): state IDLE, tx=1, fifo_rd_en=0, busy=0, frame_done=0, bytes_sent=0, baud counter 0, bit index 0, shift register 0.
- IDLE
  - If enable=1 and fifo_empty=0, go to FETCH and set fifo_rd_en=1.
  - Otherwise stay in IDLE with tx=1.
- FETCH (1 cycle)
  - fifo_rd_en is high for exactly this cycle, and the FIFO registers d_out at its end.
  - Next state is LATCH; fifo_rd_en returns to 0.
- LATCH (1 cycle)
  - fifo_data is valid during this cycle.
  - The FIFO sees the falling edge of read_en and advances its read address at the end of this cycle.
  - On exit: capture fifo_data into the shift register, compute the parity bit (even: XOR of the data bits; odd: its inverse), set tx=0, clear the baud counter, and go to START.
- START, DATA, PARITY, STOP: each bit lasts exactly CLKS_PER_BIT cycles.
  - The baud counter runs 0..CLKS_PER_BIT-1 and is $clog2(CLKS_PER_BIT) bits wide.
  - At terminal count the next bit is driven onto tx.
- DATA
  - Eight bits, LSB first.
  - The bit index runs 0..7 and is 3 bits wide.
  - After bit 7, go to PARITY if PARITY≠0, otherwise to STOP.
- PARITY: one bit time carrying the computed parity bit.
- STOP
  - tx=1 for STOP_BITS bit times.
  - At the final terminal count: go to IDLE, pulse frame_done for one cycle, increment bytes_sent, deassert busy.
- An enable drop mid-frame does not abort the frame. The current frame completes, and no new FETCH occurs until enable returns high.
- Changes on fifo_empty outside IDLE are ignored.
  - The FIFO read address has settled before IDLE is re-entered, so fifo_empty is trustworthy when next sampled.
- A reset asserted mid-frame immediately forces tx=1 and all other outputs to their reset values. The byte being sent is lost (it was already popped from the FIFO).
- Exactly one fifo_rd_en pulse is issued per frame, and never while fifo_empty=1 is sampled in IDLE.

## Timing
- Start latency:
  - Edge E0: IDLE samples enable=1 and fifo_empty=0.
  - After E0: fifo_rd_en=1.
  - After E1: fifo_rd_en=0.
  - After E2: tx=0 (start bit).
- Frame length, start bit to end of stop: (1 + 8 + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- Back-to-back frames: tx goes low 3 cycles (IDLE, FETCH, LATCH) after the final stop-bit period ends.
- busy timing: rises the cycle after E0 and falls in the same cycle frame_done is high.
- bytes_sent updates in the same cycle frame_done is high.

## Test plan
- **Reset idle:** assert reset mid-simulation without a clock edge -> tx=1, busy=0, fifo_rd_en=0, bytes_sent=0 immediately.
- **Single byte:** CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1, FIFO holds 0xA5, enable=1.
  - fifo_rd_en is high for exactly 1 cycle.
  - tx emits 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles.
  - frame_done pulses once; bytes_sent=1; FIFO reports empty.
- **Parity and stop bits:** PARITY=2, STOP_BITS=2, byte 0x03 -> parity bit 1; tx stays high 8 cycles after parity; frame is 48 cycles long.
- **Burst drain:** FIFO preloaded with 0x00..0x0E (15 entries).
  - Exactly 15 frames in order, each separated by a 3-cycle gap.
  - bytes_sent=15; no fifo_rd_en while empty.
- **Enable drop:** deassert enable during DATA bit 3 -> that frame completes intact; no further fifo_rd_en until enable rises; the next frame starts 3 edges after it does.
- **Mid-frame reset:** assert reset during DATA -> tx=1 at once; after release the block re-enters IDLE and drains the next FIFO byte normally.
